// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the oversampled UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_HIGH
  } rx_state_t;

  // Clock divider for one oversample tick, rounded to nearest, never below 1.
  function automatic int calc_div(input longint clk_hz, input longint baud,
                                  input longint os);
    longint d;
    d = (clk_hz + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : int'(d);
  endfunction

  function automatic bit cfg_ok(input int os, input int d_bits,
                                input int sp_bits, input int depth);
    return (os >= 8) && (os % 2 == 0) &&
           (d_bits >= 5) && (d_bits <= 9) &&
           (sp_bits >= 1) && (sp_bits <= 2) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is
// accepted only when a read retires the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic                       full_o,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q;
  logic                        do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD selects odd).
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 921600,
  parameter int OVERSAMPLE = 16,
  parameter int D_BITS     = 8,
  parameter int SP_BITS    = 1,
  parameter int FIFO_DEPTH = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rx,
  output logic [D_BITS-1:0]             o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic                          o_parity_err,
  input  logic                          i_clr_err
);
  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(D_BITS + 1);

  if (!cfg_ok(OVERSAMPLE, D_BITS, SP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
    $error("uart_rx_fifo: illegal parameter combination");
  end

  rx_state_t          state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [OS_W-1:0]    os_q, os_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [D_BITS-1:0]  shift_q, shift_d;
  logic               bad_q, bad_d;
  logic               frame_err_q, overrun_q;
  logic               tick, at_mid, at_end;
  logic               push, frame_set, overrun_set;
  logic               fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic               parity_err_q, par_set;
`endif

  // Divider sits at 0 in IDLE so the first tick is aligned to the start edge.
  assign tick   = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));
  assign div_d  = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
  assign at_mid = tick && (os_q == OS_W'(OVERSAMPLE / 2 - 1));
  assign at_end = tick && (os_q == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d   = state_q;
    os_d      = tick ? os_q + 1'b1 : os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    bad_d     = bad_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        os_d  = '0;
        bit_d = '0;
        bad_d = 1'b0;
        if (!rx_s_q) state_d = START;
      end
      START: if (at_mid) begin
        os_d    = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (at_end) begin
        os_d    = '0;
        shift_d = {rx_s_q, shift_q[D_BITS-1:1]};
        if (bit_q == BIT_W'(D_BITS - 1)) begin
          bit_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (at_end) begin
        os_d = '0;
        if ((^shift_q ^ rx_s_q) != PARITY_ODD) begin
          par_set = 1'b1;
          bad_d   = 1'b1;
        end
        state_d = STOP;
      end
`endif
      STOP: if (at_end) begin
        os_d = '0;
        if (!rx_s_q) begin
          frame_set = 1'b1;
          state_d   = WAIT_HIGH;
        end else if (bit_q == BIT_W'(SP_BITS - 1)) begin
          state_d = bad_q ? IDLE : PUSH;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      // A break or stuck-low line must return high before a new start is seen.
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      div_q     <= div_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      bad_q     <= bad_d;
    end
  end

  assign overrun_set = push && fifo_full && !(o_valid && i_ready);

  // Setting a flag wins over a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set)        frame_err_q <= 1'b1;
      else if (i_clr_err)   frame_err_q <= 1'b0;
      if (overrun_set)      overrun_q   <= 1'b1;
      else if (i_clr_err)   overrun_q   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)            parity_err_q <= 1'b0;
    else if (par_set)     parity_err_q <= 1'b1;
    else if (i_clr_err)   parity_err_q <= 1'b0;
  end
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  sync_fifo #(.WIDTH(D_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_en_i   (push),
    .wr_data_i (shift_q),
    .full_o    (fifo_full),
    .rd_en_i   (i_ready),
    .rd_data_o (o_data),
    .empty_o   (fifo_empty),
    .count_o   (o_count)
  );

  assign o_valid     = !fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit (DIV=1).
module tb_uart_rx_fifo;
  logic       i_clk = 1'b0;
  logic       i_rst, i_rx, i_ready, i_clr_err;
  logic [7:0] o_data;
  logic       o_valid;
  logic [4:0] o_count;
  logic       o_frame_err, o_overrun, o_parity_err;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] rxq[$];

  uart_rx_fifo #(
    .CLK_HZ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
    .D_BITS(8), .SP_BITS(1), .FIFO_DEPTH(16)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
    .o_parity_err(o_parity_err), .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  // Record every accepted word just after the falling edge.
  always begin
    @(negedge i_clk);
    #1;
    if (o_valid && i_ready) rxq.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qat(input int i);
    return (i < rxq.size()) ? rxq[i] : 8'hxx;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (16) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stp);
    i_rx = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0; i_clr_err = 1'b0;
    idle(3);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_data", o_data, 0);
    check("rst_frame", o_frame_err, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_parity", o_parity_err, 0);
    i_rst = 1'b0;
    idle(4);

    // Basic frame
    i_ready = 1'b1;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(8);
    check("basic_n", rxq.size(), 1);
    check("basic_data", qat(0), 8'hA5);
    check("basic_frame", o_frame_err, 0);
    check("basic_count", o_count, 0);
    rxq.delete();

    // False start: 5 clocks low
    i_rx = 1'b0;
    idle(5);
    i_rx = 1'b1;
    idle(40);
    check("fstart_n", rxq.size(), 0);
    check("fstart_valid", o_valid, 0);
    check("fstart_frame", o_frame_err, 0);

    // Frame error, then clear
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(8);
    check("ferr_flag", o_frame_err, 1);
    check("ferr_valid", o_valid, 0);
    check("ferr_n", rxq.size(), 0);
    i_clr_err = 1'b1;
    idle(1);
    i_clr_err = 1'b0;
    check("ferr_clr", o_frame_err, 0);

    // Overrun: 17 bytes into a 16-deep FIFO
    i_ready = 1'b0;
    for (int b = 0; b < 17; b++) send_frame(8'(b), ^(8'(b)), 1'b1);
    idle(8);
    check("ovr_count", o_count, 16);
    check("ovr_flag", o_overrun, 1);
    check("ovr_head", o_data, 8'h00);
    i_ready = 1'b1;
    idle(24);
    check("drain_n", rxq.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("drain%0d", i), qat(i), 8'(i));
    check("drain_count", o_count, 0);
    check("ovr_sticky", o_overrun, 1);
    rxq.delete();

    // Reset mid-frame with one word buffered and overrun still set
    i_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    idle(8);
    check("pre_rst_count", o_count, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    i_rx = 1'b0;
    idle(8);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    idle(1);
    check("mrst_valid", o_valid, 0);
    check("mrst_count", o_count, 0);
    check("mrst_data", o_data, 0);
    check("mrst_overrun", o_overrun, 0);
    check("mrst_frame", o_frame_err, 0);
    i_rst = 1'b0;
    idle(4);
    i_ready = 1'b1;
    rxq.delete();
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle(8);
    check("post_rst_n", rxq.size(), 1);
    check("post_rst_data", qat(0), 8'h5A);

`ifdef UART_RX_PARITY_EN
    rxq.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_ok_n", rxq.size(), 1);
    check("par_ok_data", qat(0), 8'h07);
    check("par_ok_flag", o_parity_err, 0);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(8);
    check("par_bad_n", rxq.size(), 1);
    check("par_bad_flag", o_parity_err, 1);
    check("par_bad_valid", o_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
